// File: rtl/pdm_mic_model.sv
// PDM microphone emulator: buffers signed PCM samples and replays them as a
// first-order sigma-delta bit stream clocked by an external PDM mic clock.
module pdm_mic_model #(
    parameter int SAMPLE_WIDTH = 16,
    parameter int FIFO_DEPTH   = 8,
    parameter int OSR          = 256
) (
    input  logic                            clk_in,
    input  logic                            rst_in,
    input  logic                            enable_in,
    input  logic signed [SAMPLE_WIDTH-1:0]  sample_in,
    input  logic                            sample_valid_in,
    output logic                            sample_ready_out,
    input  logic                            mic_clk_in,
    output logic                            mic_data_out,
    output logic [$clog2(FIFO_DEPTH):0]     fifo_level_out,
    output logic [7:0]                      underrun_count_out,
    output logic                            dbg_state_out
);

    localparam int AW    = $clog2(FIFO_DEPTH);
    localparam int LW    = AW + 1;
    localparam int CW    = (OSR > 1) ? $clog2(OSR) : 1;
    localparam int ACC_W = SAMPLE_WIDTH + 2;
    localparam logic signed [ACC_W-1:0] FS = {2'b00, 1'b1, {(SAMPLE_WIDTH-1){1'b0}}};

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t state_q, state_d;

    logic signed [SAMPLE_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]                  wr_ptr_q, rd_ptr_q;
    logic [LW-1:0]                  level_q;
    logic                           fifo_full, fifo_empty;
    logic                           push, pop, period_start, step, clear;
    logic                           mic_clk_q, tick_q;
    logic [CW-1:0]                  tick_cnt_q;
    logic signed [SAMPLE_WIDTH-1:0] x_q, x_cur;
    logic signed [ACC_W-1:0]        acc_q, acc_d, x_ext;
    logic                           y, data_q;
    logic [7:0]                     underrun_q;

    // Sample port handshake: a sample transfers on a clk_in edge where
    // sample_valid_in && sample_ready_out; ready comes from the registered level only.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (enable_in)  state_d = ST_RUN;
            ST_RUN:  if (!enable_in) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
        clear = (state_d == ST_IDLE);
        step  = (state_d == ST_RUN) && tick_q;
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        fifo_full    = (level_q == LW'(FIFO_DEPTH));
        fifo_empty   = (level_q == '0);
        push         = sample_valid_in && !fifo_full;
        period_start = step && (tick_cnt_q == '0);
        pop          = period_start && !fifo_empty;
        x_cur        = x_q;
        if (period_start) x_cur = fifo_empty ? '0 : mem[rd_ptr_q];
        x_ext = {{2{x_cur[SAMPLE_WIDTH-1]}}, x_cur};
        y     = !acc_q[ACC_W-1];
        acc_d = y ? (acc_q + x_ext - FS) : (acc_q + x_ext + FS);
    end

    always_ff @(posedge clk_in) begin
        if (push) mem[wr_ptr_q] <= sample_in;
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            case ({push, pop})
                2'b10:   level_q <= level_q + LW'(1);
                2'b01:   level_q <= level_q - LW'(1);
                default: level_q <= level_q;
            endcase
        end
    end

    // The falling edge is registered once more so data moves one edge after it is seen.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            mic_clk_q <= 1'b0;
            tick_q    <= 1'b0;
        end else begin
            mic_clk_q <= mic_clk_in;
            tick_q    <= ~mic_clk_in & mic_clk_q;
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            acc_q      <= '0;
            tick_cnt_q <= '0;
            x_q        <= '0;
            data_q     <= 1'b0;
        end else if (clear) begin
            acc_q      <= '0;
            tick_cnt_q <= '0;
            x_q        <= '0;
            data_q     <= 1'b0;
        end else if (step) begin
            acc_q      <= acc_d;
            tick_cnt_q <= tick_cnt_q + CW'(1);
            x_q        <= x_cur;
            data_q     <= y;
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) underrun_q <= '0;
        else if (period_start && fifo_empty && (underrun_q != 8'hFF))
            underrun_q <= underrun_q + 8'd1;
    end

    assign sample_ready_out   = !fifo_full;
    assign fifo_level_out     = level_q;
    assign mic_data_out       = data_q;
    assign underrun_count_out = underrun_q;
    assign dbg_state_out      = state_q;

endmodule
